// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO, paced by a shared oversampling tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       b_tick,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       overflow,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          par_q, tx_q, done_q, ovf_q;
  logic          push, pop, last;
  assign full     = count_q == (AW+1)'(FIFO_DEPTH);
  assign push     = wr_en && !full;
  assign pop      = state_q == IDLE && count_q != '0;
  assign last     = b_tick && tick_q == TW'(OVERSAMPLE-1);
  assign overflow = ovf_q;
  assign tx       = tx_q;
  assign tx_busy  = state_q != IDLE;
  assign tx_done  = done_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_q    <= wr_en && full;
    end
  // tx is loaded with the level of the state being entered, so it changes exactly with the state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && b_tick) tick_q <= last ? '0 : tick_q + 1'b1;
      case (state_q)
        IDLE: begin
          tick_q <= '0;
          bit_q  <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            par_q   <= ^mem_q[rd_ptr_q];
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: if (last) begin
          state_q <= DATA;
          tx_q    <= shift_q[0];
        end
        DATA: if (last) begin
          shift_q <= shift_q >> 1;
          bit_q   <= bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_q <= PARITY;
            tx_q    <= par_q;
`else
            state_q <= STOP;
            tx_q    <= 1'b1;
`endif
          end else tx_q <= shift_q[1];
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (last) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
`endif
        STOP: if (last) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule
